arbitro_balance_cajeros: RTL and testbench

// Round-robin arbiter/sequencer sharing one 64-bit account balance between N cashier

---
 rtl/arbitro_balance_cajeros_if.sv | 33 +++
 rtl/arbitro_balance_cajeros.sv | 138 +++++++++++++
 tb/tb_arbitro_balance_cajeros.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_balance_cajeros_if.sv
// Bus between the cashier controllers and the balance arbiter.
interface arbitro_balance_cajeros_if #(
  parameter int unsigned N_CAJEROS = 4,
  parameter int unsigned W_MONTO   = 32,
  parameter int unsigned W_BAL     = 64
) ();
  logic                           balance_carga;
  logic [W_BAL-1:0]               balance_inicial;
  logic [N_CAJEROS-1:0]           req;
  logic [N_CAJEROS-1:0]           tipo_trans;
  logic [N_CAJEROS*W_MONTO-1:0]   monto;
  logic [N_CAJEROS-1:0]           ack;
  logic [W_BAL-1:0]               balance_actualizado;
  logic                           balance_stb;
  logic                           entregar_dinero;
  logic                           fondos_insuficientes;
  logic                           saturado;
  logic                           ocupado;

  // Cashier side: raises requests, observes completions.
  modport master (
    output balance_carga, balance_inicial, req, tipo_trans, monto,
    input  ack, balance_actualizado, balance_stb, entregar_dinero,
           fondos_insuficientes, saturado, ocupado
  );

  // Arbiter side.
  modport slave (
    input  balance_carga, balance_inicial, req, tipo_trans, monto,
    output ack, balance_actualizado, balance_stb, entregar_dinero,
           fondos_insuficientes, saturado, ocupado
  );
endinterface

// File: rtl/arbitro_balance_cajeros.sv
// Round-robin arbiter sharing one account balance among N cashiers.
// One transaction per IDLE -> CALC -> RESP pass; result pulses during RESP.
module arbitro_balance_cajeros #(
  parameter int unsigned N_CAJEROS = 4,
  parameter int unsigned W_MONTO   = 32,
  parameter int unsigned W_BAL     = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  arbitro_balance_cajeros_if.slave  bus
);
  localparam int unsigned W_IDX = (N_CAJEROS > 1) ? $clog2(N_CAJEROS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } estado_t;

  estado_t               estado, estado_sig;
  logic [W_IDX-1:0]      ptr, idx, grant_idx;
  logic                  grant_vld;
  logic                  tipo_l;
  logic [W_MONTO-1:0]    monto_l;
  logic [W_BAL-1:0]      balance, balance_nuevo, monto_ext;
  logic [W_BAL:0]        suma;
  logic                  sat_calc, insuf_calc, entregar_calc;
  logic [N_CAJEROS-1:0]  ack_calc, ack_r;
  logic                  stb_r, entregar_r, insuf_r, sat_r;
  int unsigned           cand;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) estado <= IDLE;
    else       estado <= estado_sig;
  end

  // Round-robin pick, balance arithmetic and next-state decode.
  always_comb begin
    estado_sig    = estado;
    grant_vld     = 1'b0;
    grant_idx     = ptr;
    cand          = 0;
    monto_ext     = '0;
    suma          = '0;
    balance_nuevo = balance;
    sat_calc      = 1'b0;
    insuf_calc    = 1'b0;
    entregar_calc = 1'b0;
    ack_calc      = '0;

    // Scan ptr+1, ptr+2, ... wrapping at N; the first hit wins.
    for (int unsigned k = 1; k <= N_CAJEROS; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N_CAJEROS) cand = cand - N_CAJEROS;
      if (!grant_vld && bus.req[cand[W_IDX-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[W_IDX-1:0];
      end
    end

    monto_ext[W_MONTO-1:0] = monto_l;
    suma = {1'b0, balance} + {1'b0, monto_ext};
    if (!tipo_l) begin
      if (suma[W_BAL]) begin
        balance_nuevo = '1;
        sat_calc      = 1'b1;
      end else begin
        balance_nuevo = suma[W_BAL-1:0];
      end
    end else if (monto_ext > balance) begin
      insuf_calc = 1'b1;
    end else begin
      balance_nuevo = balance - monto_ext;
      entregar_calc = 1'b1;
    end
    ack_calc[idx] = 1'b1;

    case (estado)
      IDLE:    if (!bus.balance_carga && grant_vld) estado_sig = CALC;
      CALC:    estado_sig = RESP;
      RESP:    estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  // Datapath: latch the granted request, commit the balance, register result pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= W_IDX'(N_CAJEROS - 1);
      idx        <= '0;
      tipo_l     <= 1'b0;
      monto_l    <= '0;
      balance    <= '0;
      ack_r      <= '0;
      stb_r      <= 1'b0;
      entregar_r <= 1'b0;
      insuf_r    <= 1'b0;
      sat_r      <= 1'b0;
    end else begin
      ack_r      <= '0;
      stb_r      <= 1'b0;
      entregar_r <= 1'b0;
      insuf_r    <= 1'b0;
      sat_r      <= 1'b0;
      case (estado)
        IDLE: begin
          if (bus.balance_carga) begin
            balance <= bus.balance_inicial;
          end else if (grant_vld) begin
            idx     <= grant_idx;
            tipo_l  <= bus.tipo_trans[grant_idx];
            monto_l <= bus.monto[grant_idx*W_MONTO +: W_MONTO];
          end
        end
        // Pulses are registered here so they are visible exactly during RESP.
        CALC: begin
          balance    <= balance_nuevo;
          ack_r      <= ack_calc;
          stb_r      <= !insuf_calc;
          entregar_r <= entregar_calc;
          insuf_r    <= insuf_calc;
          sat_r      <= sat_calc;
        end
        RESP:    ptr <= idx;
        default: ;
      endcase
    end
  end

  assign bus.ack                  = ack_r;
  assign bus.balance_actualizado  = balance;
  assign bus.balance_stb          = stb_r;
  assign bus.entregar_dinero      = entregar_r;
  assign bus.fondos_insuficientes = insuf_r;
  assign bus.saturado             = sat_r;
  assign bus.ocupado              = (estado != IDLE);
endmodule

// File: tb/tb_arbitro_balance_cajeros.sv
// Bench for arbitro_balance_cajeros: directed cases then randomized traffic
// against a transaction-level model of balance and round-robin order.
module tb_arbitro_balance_cajeros;
  localparam int unsigned N  = 4;
  localparam int unsigned WM = 32;
  localparam int unsigned WB = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arbitro_balance_cajeros_if #(.N_CAJEROS(N), .W_MONTO(WM), .W_BAL(WB)) bus ();

  arbitro_balance_cajeros #(.N_CAJEROS(N), .W_MONTO(WM), .W_BAL(WB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model state
  logic [WB-1:0] m_bal;
  int            m_ptr;
  bit            m_req   [N];
  bit            m_tipo  [N];
  logic [WM-1:0] m_monto [N];
  bit            t_carga;
  logic [WB-1:0] t_ini;
  logic [WB-1:0] MAXB;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req[i]            = m_req[i];
      bus.tipo_trans[i]     = m_tipo[i];
      bus.monto[i*WM +: WM] = m_monto[i];
    end
    bus.balance_carga   = t_carga;
    bus.balance_inicial = t_ini;
  endtask

  task automatic model_reset();
    m_bal = '0;
    m_ptr = N - 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load(input logic [WB-1:0] v);
    t_carga = 1'b1;
    t_ini   = v;
    drive();
    step();
    m_bal = v;
    chk("load_bal", bus.balance_actualizado, m_bal);
    chk("load_idle", {63'd0, bus.ocupado}, 64'd0);
    chk("load_noack", {60'd0, bus.ack}, 64'd0);
    t_carga = 1'b0;
    drive();
  endtask

  task automatic new_req(input int i);
    int r;
    m_req[i]  = ($urandom_range(0, 3) != 0);
    m_tipo[i] = $urandom_range(0, 1) == 1;
    r = $urandom_range(0, 9);
    if (r == 0)                  m_monto[i] = '0;
    else if (r <= 2)             m_monto[i] = $urandom;
    else if (r == 3 && m_bal < 64'h1_0000_0000) m_monto[i] = m_bal[WM-1:0];
    else                         m_monto[i] = $urandom_range(0, 1000);
  endtask

  // mode 0: winner drops req; 1: winner keeps req; 2: winner gets a fresh random request.
  // carga_calc drives balance_carga while the arbiter is busy; it must be ignored.
  task automatic txn(input int mode, input bit carga_calc);
    int            w;
    logic [WB-1:0] nb, mon;
    bit            e_sat, e_ins, e_ent;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (m_req[c] && w < 0) w = c;
    end
    if (w < 0) begin
      chk("txn_no_request", 64'd0, 64'd1);
      return;
    end
    mon   = {32'd0, m_monto[w]};
    e_sat = 1'b0; e_ins = 1'b0; e_ent = 1'b0;
    if (!m_tipo[w]) begin
      if (mon > MAXB - m_bal) begin nb = MAXB; e_sat = 1'b1; end
      else nb = m_bal + mon;
    end else begin
      if (mon > m_bal) begin nb = m_bal; e_ins = 1'b1; end
      else begin nb = m_bal - mon; e_ent = 1'b1; end
    end

    drive();
    step();
    chk("calc_busy", {63'd0, bus.ocupado}, 64'd1);
    chk("calc_noack", {60'd0, bus.ack}, 64'd0);
    if (carga_calc) begin
      t_carga = 1'b1;
      t_ini   = {$urandom, $urandom};
      drive();
    end
    step();
    chk("resp_ack", {60'd0, bus.ack}, 64'd1 << w);
    chk("resp_bal", bus.balance_actualizado, nb);
    chk("resp_stb", {63'd0, bus.balance_stb}, {63'd0, !e_ins});
    chk("resp_entregar", {63'd0, bus.entregar_dinero}, {63'd0, e_ent});
    chk("resp_insuf", {63'd0, bus.fondos_insuficientes}, {63'd0, e_ins});
    chk("resp_sat", {63'd0, bus.saturado}, {63'd0, e_sat});
    chk("resp_busy", {63'd0, bus.ocupado}, 64'd1);
    m_bal   = nb;
    m_ptr   = w;
    t_carga = 1'b0;
    if (mode == 0)      m_req[w] = 1'b0;
    else if (mode == 2) new_req(w);
    drive();
    step();
    chk("post_noack", {60'd0, bus.ack}, 64'd0);
    chk("post_idle", {63'd0, bus.ocupado}, 64'd0);
    chk("post_nostb", {63'd0, bus.balance_stb}, 64'd0);
    chk("post_bal", bus.balance_actualizado, m_bal);
  endtask

  task automatic set_req(input int i, input bit tipo, input logic [WM-1:0] v);
    m_req[i] = 1'b1; m_tipo[i] = tipo; m_monto[i] = v;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) m_req[i] = 1'b0;
    drive();
  endtask

  initial begin
    MAXB    = '1;
    t_carga = 1'b0;
    t_ini   = '0;
    for (int i = 0; i < N; i++) begin
      m_req[i] = 1'b0; m_tipo[i] = 1'b0; m_monto[i] = '0;
    end
    drive();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_reset();
    chk("rst_bal", bus.balance_actualizado, 64'd0);
    chk("rst_ack", {60'd0, bus.ack}, 64'd0);
    chk("rst_busy", {63'd0, bus.ocupado}, 64'd0);
    chk("rst_stb", {63'd0, bus.balance_stb}, 64'd0);
    chk("rst_flags", {61'd0, bus.entregar_dinero, bus.fondos_insuficientes, bus.saturado}, 64'd0);

    // Load 1000 with a request already pending: load wins, then deposit 250.
    set_req(0, 1'b0, 250);
    load(64'd1000);
    txn(0, 1'b0);

    // Rejected and exact withdrawals.
    load(64'd100);
    set_req(2, 1'b1, 101);
    txn(0, 1'b0);
    set_req(2, 1'b1, 100);
    txn(0, 1'b0);

    // Zero amounts.
    load(64'd500);
    set_req(1, 1'b0, 0);
    txn(0, 1'b0);
    set_req(1, 1'b1, 0);
    txn(0, 1'b0);

    // All requests held from reset: grants rotate 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1);
    for (int n = 0; n < 5; n++) txn(1, 1'b0);
    clear_reqs();

    // Saturating deposit.
    load(64'hFFFF_FFFF_FFFF_FFF6);
    set_req(3, 1'b0, 20);
    txn(0, 1'b0);

    // balance_carga outside IDLE is ignored.
    load(64'd5000);
    set_req(1, 1'b1, 300);
    txn(0, 1'b1);

    // Reset while in CALC aborts the transaction.
    load(64'd77);
    set_req(0, 1'b0, 5);
    drive();
    step();
    chk("abort_busy", {63'd0, bus.ocupado}, 64'd1);
    reset = 1'b1;
    step();
    chk("abort_noack", {60'd0, bus.ack}, 64'd0);
    chk("abort_bal", bus.balance_actualizado, 64'd0);
    chk("abort_idle", {63'd0, bus.ocupado}, 64'd0);
    reset = 1'b0;
    model_reset();
    clear_reqs();
    step();
    chk("abort_nolinger", {63'd0, bus.ocupado}, 64'd0);
    chk("abort_nolinger_ack", {60'd0, bus.ack}, 64'd0);

    // Randomized traffic with persistent pending requests.
    for (int i = 0; i < N; i++) new_req(i);
    for (int it = 0; it < 200; it++) begin
      bit any;
      if (it % 20 == 0) begin
        case ($urandom_range(0, 2))
          0:       load({32'hFFFF_FFFF, 32'($urandom)});
          1:       load({32'($urandom), 32'($urandom)});
          default: load(64'($urandom_range(0, 5000)));
        endcase
      end
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= m_req[i];
      if (!any) begin
        int j;
        j = $urandom_range(0, N - 1);
        new_req(j);
        m_req[j] = 1'b1;
      end
      txn(2, $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
